ram_arbiter: RTL and testbench

Shares the single-port 32KB main RAM between the 6502 CPU and a secondary bus master (DMA/video/loader) in the 25 MHz domain. The CPU accesses memory only on `cpu_clk_enable` cycles, so most RAM cycles sit idle. This block grants those idle cycles to the secondary requester. It reserves a guard window before each CPU enable, and holds the CPU's read data stable, so CPU timing is unchanged. It sits between the CPU/address decoder and the `ram` instance in `soc_top`.

---
 rtl/ram_arbiter.sv | 74 +++++++
 tb/tb_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares the single-port main RAM between the CPU and a secondary bus master.
// The secondary master borrows RAM cycles between CPU enables, outside a guard window.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 25,
    parameter int GUARD      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_clk_enable,
    input  logic                  cpu_ram_cs,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] P_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1 - GUARD);

    logic [PW-1:0]         p_reg;
    logic                  synced_reg;
    logic                  own_cpu_q;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  gnt;

    // The enable cycle always belongs to the CPU, even when it arrives off-phase.
    assign gnt = !rst && dma_req && synced_reg && !cpu_clk_enable && (p_reg <= P_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg      <= '0;
            synced_reg <= 1'b0;
            own_cpu_q  <= 1'b1;
            rvalid_reg <= 1'b0;
            hold_reg   <= '0;
        end else begin
            if (cpu_clk_enable) begin
                p_reg      <= '0;
                synced_reg <= 1'b1;
            end else if (p_reg != P_MAX) begin
                p_reg <= p_reg + 1'b1;
            end
            own_cpu_q  <= !gnt;
            rvalid_reg <= gnt && !dma_we;
            // Capture whatever the CPU's own address produced so DMA cycles can't disturb it.
            if (own_cpu_q) begin
                hold_reg <= ram_rdata;
            end
        end
    end

    assign dma_gnt    = gnt;
    assign dma_rvalid = rvalid_reg && !rst;
    assign dma_rdata  = ram_rdata;
    assign ram_we     = gnt ? dma_we : (!rst && cpu_clk_enable && cpu_ram_cs && cpu_we);
    assign ram_addr   = gnt ? dma_addr  : cpu_addr;
    assign ram_wdata  = gnt ? dma_wdata : cpu_wdata;
    assign cpu_rdata  = own_cpu_q ? ram_rdata : hold_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM model plus a cycle-level reference of who owns each RAM
// cycle and what data each master last read, driven by directed and random traffic.
module tb_ram_arbiter;
    localparam int AW      = 15;
    localparam int DW      = 8;
    localparam int CLK_DIV = 25;
    localparam int GUARD   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst            = 1'b1;
    logic          cpu_clk_enable = 1'b0;
    logic          cpu_ram_cs     = 1'b0;
    logic          cpu_we         = 1'b0;
    logic [AW-1:0] cpu_addr       = '0;
    logic [DW-1:0] cpu_wdata      = '0;
    logic          dma_req        = 1'b0;
    logic          dma_we         = 1'b0;
    logic [AW-1:0] dma_addr       = '0;
    logic [DW-1:0] dma_wdata      = '0;
    logic [DW-1:0] cpu_rdata, dma_rdata, ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          dma_gnt, dma_rvalid, ram_we;
    logic [AW-1:0] ram_addr;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
        .clk(clk), .rst(rst), .cpu_clk_enable(cpu_clk_enable), .cpu_ram_cs(cpu_ram_cs),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ {a[14:11], a[3:0]} ^ 8'h5C;
    endfunction

    // RAM with registered, read-before-write output
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    bit            ram_wr  [0:(1<<AW)-1];
    always @(posedge clk) begin
        ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            ram_wr[ram_addr]  <= 1'b1;
        end
    end

    // Reference state
    logic [DW-1:0] ref_mem [int];
    bit            m_synced    = 1'b0;
    int            m_cnt       = 0;
    bit            m_rd_pend   = 1'b0;
    bit            m_cpu_known = 1'b0;
    logic [DW-1:0] m_last_read = '0;
    logic [DW-1:0] m_cpu_val   = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int total_gnt = 0;
    logic          obs_gnt, obs_rvalid, obs_we;
    logic [DW-1:0] obs_rdata, obs_cpu_rdata;
    int            obs_p;
    int            g0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance the reference.
    task automatic tick();
        logic          eg, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, rd;
        @(negedge clk);
        eg  = !rst && dma_req && m_synced && !cpu_clk_enable && (m_cnt <= CLK_DIV - 1 - GUARD);
        ea  = eg ? dma_addr : cpu_addr;
        ewd = eg ? dma_wdata : cpu_wdata;
        ewe = rst ? 1'b0 : (eg ? dma_we : (cpu_clk_enable && cpu_ram_cs && cpu_we));
        chk("gnt", dma_gnt, eg);
        chk("ram_we", ram_we, ewe);
        chk("ram_addr", ram_addr, ea);
        if (ewe) chk("ram_wdata", ram_wdata, ewd);
        chk("rvalid", dma_rvalid, m_rd_pend && !rst);
        if (m_rd_pend && !rst) chk("dma_rdata", dma_rdata, m_last_read);
        if (m_cpu_known) chk("cpu_rdata", cpu_rdata, m_cpu_val);
        obs_gnt = dma_gnt; obs_rvalid = dma_rvalid; obs_we = ram_we;
        obs_rdata = dma_rdata; obs_cpu_rdata = cpu_rdata; obs_p = m_cnt;
        if (eg) begin
            total_gnt++;
            $display("DMA %s addr=%h wdata=%h p=%0d", dma_we ? "WR" : "RD", dma_addr, dma_wdata, m_cnt);
        end
        if (cpu_clk_enable && !rst)
            $display("CPU EN cs=%0b we=%0b addr=%h wdata=%h rdata=%h p=%0d",
                     cpu_ram_cs, cpu_we, cpu_addr, cpu_wdata, cpu_rdata, m_cnt);
        rd = ref_rd(ea);
        if (ewe) ref_mem[int'(ea)] = ewd;
        m_last_read = rd;
        if (!eg) begin
            m_cpu_val   = rd;
            m_cpu_known = 1'b1;
        end
        m_rd_pend = eg && !dma_we;
        if (rst) begin
            m_synced = 1'b0;
            m_cnt    = 0;
        end else if (cpu_clk_enable) begin
            m_synced = 1'b1;
            m_cnt    = 0;
        end else if (m_cnt < CLK_DIV - 1) begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_p(input int target);
        int guard_cnt = 0;
        while (m_cnt != target && guard_cnt < 64) begin
            tick();
            guard_cnt++;
        end
        if (m_cnt != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL phase_timeout got=%0d exp=%0d", m_cnt, target);
        end
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        run_to_p(CLK_DIV - 1);
        cpu_addr = a; cpu_ram_cs = 1'b1; cpu_we = 1'b1; cpu_wdata = d; cpu_clk_enable = 1'b1;
        tick();
        cpu_clk_enable = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        // Request pending across reset and before the first enable
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h1234; dma_wdata = 8'hA7;
        repeat (3) tick();
        chk("rst_gnt", obs_gnt, 0);
        chk("rst_rvalid", obs_rvalid, 0);
        chk("rst_we", obs_we, 0);
        rst = 1'b0;
        g0 = total_gnt;
        repeat (12) tick();
        chk("presync_gnt_cnt", total_gnt - g0, 0);
        cpu_clk_enable = 1'b1;
        tick();
        cpu_clk_enable = 1'b0;
        chk("presync_en_gnt", obs_gnt, 0);
        tick();
        chk("first_gnt", obs_gnt, 1);
        chk("first_gnt_p", obs_p, 0);
        dma_req = 1'b0;

        // Idle DMA: CPU write then read back at the next enable
        cpu_write(15'h0200, 8'h5A);
        g0 = total_gnt;
        run_to_p(CLK_DIV - 1);
        cpu_clk_enable = 1'b1;
        tick();
        cpu_clk_enable = 1'b0;
        chk("idle_cpu_rdata", obs_cpu_rdata, 8'h5A);
        chk("idle_gnt_cnt", total_gnt - g0, 0);

        // Single DMA read at p=5
        run_to_p(5);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h1234;
        tick();
        dma_req = 1'b0;
        chk("rd_gnt", obs_gnt, 1);
        chk("rd_gnt_p", obs_p, 5);
        tick();
        chk("rd_rvalid", obs_rvalid, 1);
        chk("rd_rvalid_p", obs_p, 6);
        chk("rd_data", obs_rdata, 8'hA7);

        cpu_write(15'h0010, 8'h3C);
        cpu_write(15'h0011, 8'h11);

        // Continuous DMA reads across two CPU cycles
        cpu_addr = 15'h0010; dma_req = 1'b1; dma_we = 1'b0; dma_addr = AW'($urandom_range(0, 63));
        for (int c = 0; c < 2; c++) begin
            g0 = total_gnt;
            for (int k = 0; k < CLK_DIV; k++) begin
                tick();
                if (k >= CLK_DIV - GUARD) chk("stall_guard_gnt", obs_gnt, 0);
                if (k >= CLK_DIV - GUARD + 1) chk("stall_cpu_rdata", obs_cpu_rdata, 8'h3C);
                if (obs_gnt) dma_addr = AW'($urandom_range(0, 63));
            end
            cpu_clk_enable = 1'b1;
            tick();
            cpu_clk_enable = 1'b0;
            chk("stall_en_gnt", obs_gnt, 0);
            chk("stall_en_rdata", obs_cpu_rdata, 8'h3C);
            chk("stall_gnt_count", total_gnt - g0, CLK_DIV - GUARD);
        end

        // CPU read data must not move during a DMA write
        dma_req = 1'b0; cpu_addr = 15'h0011;
        run_to_p(8);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0010; dma_wdata = 8'h99;
        tick();
        dma_req = 1'b0;
        chk("stable_gnt", obs_gnt, 1);
        chk("stable_dma_cycle", obs_cpu_rdata, 8'h11);
        tick();
        chk("stable_after", obs_cpu_rdata, 8'h11);

        // Early enable at p=10, then reset right after a read grant
        run_to_p(CLK_DIV - 1);
        cpu_clk_enable = 1'b1;
        tick();
        cpu_clk_enable = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0011;
        run_to_p(10);
        cpu_clk_enable = 1'b1;
        tick();
        cpu_clk_enable = 1'b0;
        chk("early_en_gnt", obs_gnt, 0);
        chk("early_en_p", obs_p, 10);
        tick();
        chk("resync_gnt", obs_gnt, 1);
        chk("resync_p", obs_p, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rvalid", obs_rvalid, 0);
        chk("midrst_gnt", obs_gnt, 0);
        chk("midrst_we", obs_we, 0);
        tick();
        chk("postrst_rvalid", obs_rvalid, 0);
        chk("postrst_gnt", obs_gnt, 0);
        chk("postrst_we", obs_we, 0);
        dma_req = 1'b0;

        // Random traffic with occasional early and late enables
        for (int i = 0; i < 400; i++) begin
            cpu_clk_enable = (m_cnt == CLK_DIV - 1 && $urandom_range(0, 9) != 0) ||
                             ($urandom_range(0, 49) == 0);
            if (cpu_clk_enable) begin
                cpu_ram_cs = 1'($urandom_range(0, 1));
                cpu_we     = 1'($urandom_range(0, 1));
                cpu_addr   = AW'($urandom_range(0, 31));
                cpu_wdata  = DW'($urandom);
            end
            if (!dma_req || obs_gnt) begin
                dma_req   = 1'($urandom_range(0, 1));
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = AW'($urandom_range(0, 31));
                dma_wdata = DW'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
